csr_file_m: RTL
===============

# csr_file_m

Parametrised machine-mode CSR file for the RV32 core. Holds the M-mode CSRs, executes CSRRW/RS/RC(I), arbitrates synchronous traps, prioritised interrupts and MRET, and drives a registered PC redirect plus the current privilege to the pipeline. Adds vectored mtvec, configurable platform interrupt lines, 64-bit counters with inhibit, and access checking.

## Interface
Parameters:
- NUM_PLAT_IRQ, 4: platform interrupt lines mapped to mip/mie bits 16..16+NUM_PLAT_IRQ-1; range 0..16.
- RESET_MTVEC, 32'h0000_0100: mtvec reset value.
- MIMPID_VAL, 32'h0000_0002: mimpid read value.
- VECTORED_EN, 1: 0 forces mtvec.MODE to direct.

Ports (clock and reset first):
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- csr_valid  in  1  CSR instruction in execute this cycle
- csr_addr  in  12  CSR address
- csr_op  in  3  funct3: 001 RW, 010 RS, 011 RC, 101/110/111 immediate forms
- csr_src_zero  in  1  rs1 is x0 / uimm is 0
- csr_wdata  in  32  rs1 value or zero-extended uimm
- csr_rdata  out  32  old CSR value, combinational
- csr_illegal  out  1  access illegal, combinational
- retire  in  1  one instruction retired
- trap_valid  in  1  synchronous exception
- trap_pc  in  32  faulting PC
- trap_cause  in  5  exception code
- trap_tval  in  32  mtval value
- mret  in  1  MRET in execute
- current_pc  in  32  PC of next unexecuted instruction
- irq_sw, irq_timer, irq_ext  in  1 each  level interrupt requests
- irq_plat  in  NUM_PLAT_IRQ  level platform requests
- redirect_valid  out  1  registered, one-cycle pulse
- redirect_pc  out  32  registered target
- priv  out  2  11 = M, 00 = U

## Operation
- CSRs: mstatus 0x300 (MIE b3, MPIE b7, MPP b12:11; other bits read 0), misa 0x301 (RV32IMU, read-only by WARL), mie 0x304, mtvec 0x305, mcountinhibit 0x320 (bits 0, 2), mscratch 0x340, mepc 0x341 (bits 1:0 read 0), mcause 0x342, mtval 0x343, mip 0x344 (read-only, reflects inputs), mcycle/mcycleh 0xB00/0xB80, minstret/minstreth 0xB02/0xB82, mvendorid/marchid/mhartid = 0, mimpid = MIMPID_VAL.
- Write value: RW = wdata; RS = old | wdata; RC = old & ~wdata. RS/RC with csr_src_zero perform no write. RW always writes.
- Illegal: unmapped address; a write to addr[11:10]=11; or priv < addr[9:8]. An illegal access has no side effects. The core raises the trap.
- Event priority per cycle: reset > trap_valid > interrupt > mret > CSR write.
- Interrupt pending: pend = mip & mie. It is taken when pend≠0 and (priv==U or MIE). Selection order: MEI(11) > MSI(3) > MTI(7) > platform, lowest index first.
- Trap/interrupt entry:
  - mepc = trap_pc (trap) or current_pc (interrupt).
  - mcause = {0, cause} or {1, code}.
  - mtval = trap_tval, or 0 for an interrupt.
  - MPIE = MIE, MIE = 0, MPP = priv, priv = M.
  - redirect_pc = mtvec base, or base + 4·code for an interrupt when MODE=01.
- MRET: MIE = MPIE, MPIE = 1, priv = MPP, MPP = U, redirect_pc = mepc.
- mtvec write: MODE values other than 00/01 are stored as 00.
- Counters are 64-bit.
  - mcycle increments every cycle unless inhibit bit 0 is set.
  - minstret increments on retire unless inhibit bit 2 is set.
  - A CSR write to either half wins over the increment for that cycle. The other half holds; the carry is dropped that cycle.

## Timing
- Reset values: priv = M, mstatus = 0, mie = 0, mtvec = RESET_MTVEC, mepc/mcause/mtval/mscratch = 0, counters = 0, mcountinhibit = 0, redirect_valid = 0, redirect_pc = 0.
- Reset mid-operation discards any pending redirect the next cycle.
- CSR writes and state updates occur at the clk edge. csr_rdata returns the pre-write value in the same cycle.
- redirect_valid/pc assert exactly one cycle after trap, interrupt or mret.
- An interrupt is blocked in the cycle redirect_valid is high, so at most one entry fires per redirect.
- A trap in the same cycle as a CSR write drops the write. An interrupt in the same cycle as an mret drops the mret; mepc = current_pc.

## Structure
- Package csr_pkg: CSR address localparams, mstatus bit indices, cause codes, csr_op encodings, privilege encodings.
- Sub-module csr_irq_arb: combinational priority selector taking pend, returning take and a 5-bit code.

## Test plan
- CSRRW 0x340 with 0xDEADBEEF, then CSRRS with 0x1 -> rdata returns 0x0 then 0xDEADBEEF; mscratch becomes 0xDEADBEEF.
- mtvec = 0x201, mie = 0x880, MIE = 1, irq_timer and irq_ext both high -> the next cycle shows redirect_pc = 0x22C, mcause = 0x8000000B and MIE = 0.
- trap_valid with cause 2 at trap_pc 0x40, a CSRRW to mscratch in the same cycle -> mepc = 0x40, mcause = 2, mscratch unchanged, redirect_pc = mtvec base.
- Enter U via MRET with MPP = 00 -> priv = 00. A CSRRW to 0x300 then gives csr_illegal = 1 and mstatus unchanged. MIE = 0 with pending MEI still takes the interrupt.
- mcycle = 0xFFFFFFFF -> the next cycle gives mcycleh incremented by 1. Setting mcountinhibit = 1 freezes mcycle while minstret still counts retire.
- Assert reset while redirect is due -> redirect_valid stays 0; priv = M.

Source files
------------

// File: rtl/csr_pkg.sv
// Shared encodings for the machine-mode CSR file: addresses, mstatus fields,
// interrupt cause codes, csr_op decoding and privilege levels.
package csr_pkg;

  localparam logic [11:0] CSR_MSTATUS       = 12'h300;
  localparam logic [11:0] CSR_MISA          = 12'h301;
  localparam logic [11:0] CSR_MIE           = 12'h304;
  localparam logic [11:0] CSR_MTVEC         = 12'h305;
  localparam logic [11:0] CSR_MCOUNTINHIBIT = 12'h320;
  localparam logic [11:0] CSR_MSCRATCH      = 12'h340;
  localparam logic [11:0] CSR_MEPC          = 12'h341;
  localparam logic [11:0] CSR_MCAUSE        = 12'h342;
  localparam logic [11:0] CSR_MTVAL         = 12'h343;
  localparam logic [11:0] CSR_MIP           = 12'h344;
  localparam logic [11:0] CSR_MCYCLE        = 12'hB00;
  localparam logic [11:0] CSR_MINSTRET      = 12'hB02;
  localparam logic [11:0] CSR_MCYCLEH       = 12'hB80;
  localparam logic [11:0] CSR_MINSTRETH     = 12'hB82;
  localparam logic [11:0] CSR_MVENDORID     = 12'hF11;
  localparam logic [11:0] CSR_MARCHID       = 12'hF12;
  localparam logic [11:0] CSR_MIMPID        = 12'hF13;
  localparam logic [11:0] CSR_MHARTID       = 12'hF14;

  localparam int MSTATUS_MIE    = 3;
  localparam int MSTATUS_MPIE   = 7;
  localparam int MSTATUS_MPP_LO = 11;
  localparam int MSTATUS_MPP_HI = 12;

  localparam logic [4:0] IRQ_CODE_MSI   = 5'd3;
  localparam logic [4:0] IRQ_CODE_MTI   = 5'd7;
  localparam logic [4:0] IRQ_CODE_MEI   = 5'd11;
  localparam int         IRQ_PLAT_BASE  = 16;

  // RV32 (MXL=1) with I, M and U extensions
  localparam logic [31:0] MISA_VAL = 32'h4010_1100;

  localparam logic [1:0] PRIV_U = 2'b00;
  localparam logic [1:0] PRIV_M = 2'b11;

  // Low two bits of funct3; the immediate forms share the same behaviour.
  typedef enum logic [1:0] {
    CSR_OP_NONE = 2'b00,
    CSR_OP_RW   = 2'b01,
    CSR_OP_RS   = 2'b10,
    CSR_OP_RC   = 2'b11
  } csr_op_e;

  function automatic logic [31:0] csr_apply(input csr_op_e op,
                                            input logic [31:0] old_val,
                                            input logic [31:0] wdata);
    case (op)
      CSR_OP_RS: return old_val | wdata;
      CSR_OP_RC: return old_val & ~wdata;
      default:   return wdata;
    endcase
  endfunction

endpackage

// File: rtl/csr_file_m_irq_arb.sv
// Fixed-priority interrupt selector: MEI > MSI > MTI > platform lines,
// lowest platform index first.
module csr_irq_arb
  import csr_pkg::*;
#(
  parameter int NUM_PLAT_IRQ = 4
) (
  input  logic [31:0] pend,
  output logic        take,
  output logic [4:0]  code
);

  always_comb begin
    take = |pend;
    code = IRQ_CODE_MEI;
    if (pend[IRQ_CODE_MEI]) begin
      code = IRQ_CODE_MEI;
    end else if (pend[IRQ_CODE_MSI]) begin
      code = IRQ_CODE_MSI;
    end else if (pend[IRQ_CODE_MTI]) begin
      code = IRQ_CODE_MTI;
    end else begin
      // Scan downward so the lowest pending index is the last to assign.
      for (int i = NUM_PLAT_IRQ - 1; i >= 0; i--) begin
        if (pend[IRQ_PLAT_BASE + i]) code = 5'(IRQ_PLAT_BASE + i);
      end
    end
  end

endmodule

// File: rtl/csr_file_m.sv
// Machine-mode CSR file: CSR access, trap/interrupt/MRET sequencing,
// 64-bit counters and a registered PC redirect toward the pipeline.
module csr_file_m
  import csr_pkg::*;
#(
  parameter int          NUM_PLAT_IRQ = 4,
  parameter logic [31:0] RESET_MTVEC  = 32'h0000_0100,
  parameter logic [31:0] MIMPID_VAL   = 32'h0000_0002,
  parameter bit          VECTORED_EN  = 1'b1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    csr_valid,
  input  logic [11:0]             csr_addr,
  input  logic [2:0]              csr_op,
  input  logic                    csr_src_zero,
  input  logic [31:0]             csr_wdata,
  output logic [31:0]             csr_rdata,
  output logic                    csr_illegal,
  input  logic                    retire,
  input  logic                    trap_valid,
  input  logic [31:0]             trap_pc,
  input  logic [4:0]              trap_cause,
  input  logic [31:0]             trap_tval,
  input  logic                    mret,
  input  logic [31:0]             current_pc,
  input  logic                    irq_sw,
  input  logic                    irq_timer,
  input  logic                    irq_ext,
  input  logic [NUM_PLAT_IRQ-1:0] irq_plat,
  output logic                    redirect_valid,
  output logic [31:0]             redirect_pc,
  output logic [1:0]              priv
);

  localparam logic [31:0] PLAT_MASK = (NUM_PLAT_IRQ == 0) ? 32'h0 :
                                      (((32'h1 << NUM_PLAT_IRQ) - 32'h1) << IRQ_PLAT_BASE);
  localparam logic [31:0] MIE_MASK  = 32'h0000_0888 | PLAT_MASK;

  logic [1:0]  priv_q;
  logic        mie_q, mpie_q;
  logic [1:0]  mpp_q;
  logic [31:0] irq_en_q;
  logic [31:0] mtvec_q;
  logic [31:0] mscratch_q, mepc_q, mcause_q, mtval_q;
  logic        cy_inh_q, ir_inh_q;
  logic [63:0] mcycle_q, minstret_q;
  logic        redirect_valid_q;
  logic [31:0] redirect_pc_q;

  logic [31:0] mip, pend, mstatus_val, rd_val, wr_val, vec_base, trap_target;
  logic        mapped, wr_req, illegal, csr_we;
  logic        arb_take, irq_fire, mret_fire;
  logic [4:0]  irq_code;
  csr_op_e     op;

  always_comb begin
    mip = '0;
    mip[IRQ_CODE_MSI] = irq_sw;
    mip[IRQ_CODE_MTI] = irq_timer;
    mip[IRQ_CODE_MEI] = irq_ext;
    for (int i = 0; i < NUM_PLAT_IRQ; i++) mip[IRQ_PLAT_BASE + i] = irq_plat[i];
  end

  assign pend = mip & irq_en_q;

  csr_irq_arb #(.NUM_PLAT_IRQ(NUM_PLAT_IRQ)) u_irq_arb (
    .pend (pend),
    .take (arb_take),
    .code (irq_code)
  );

  assign mstatus_val = {19'b0, mpp_q, 3'b0, mpie_q, 3'b0, mie_q, 3'b0};

  always_comb begin
    rd_val = '0;
    mapped = 1'b1;
    case (csr_addr)
      CSR_MSTATUS:       rd_val = mstatus_val;
      CSR_MISA:          rd_val = MISA_VAL;
      CSR_MIE:           rd_val = irq_en_q;
      CSR_MTVEC:         rd_val = mtvec_q;
      CSR_MCOUNTINHIBIT: rd_val = {29'b0, ir_inh_q, 1'b0, cy_inh_q};
      CSR_MSCRATCH:      rd_val = mscratch_q;
      CSR_MEPC:          rd_val = mepc_q;
      CSR_MCAUSE:        rd_val = mcause_q;
      CSR_MTVAL:         rd_val = mtval_q;
      CSR_MIP:           rd_val = mip;
      CSR_MCYCLE:        rd_val = mcycle_q[31:0];
      CSR_MCYCLEH:       rd_val = mcycle_q[63:32];
      CSR_MINSTRET:      rd_val = minstret_q[31:0];
      CSR_MINSTRETH:     rd_val = minstret_q[63:32];
      CSR_MVENDORID,
      CSR_MARCHID,
      CSR_MHARTID:       rd_val = '0;
      CSR_MIMPID:        rd_val = MIMPID_VAL;
      default:           mapped = 1'b0;
    endcase
  end

  assign op     = csr_op_e'(csr_op[1:0]);
  assign wr_req = csr_valid && ((op == CSR_OP_RW) ||
                  (((op == CSR_OP_RS) || (op == CSR_OP_RC)) && !csr_src_zero));
  assign wr_val = csr_apply(op, rd_val, csr_wdata);

  assign illegal = csr_valid && (!mapped ||
                   (wr_req && (csr_addr[11:10] == 2'b11)) ||
                   (priv_q < csr_addr[9:8]));

  // Interrupts wait out the redirect cycle so each redirect carries one entry.
  assign irq_fire  = arb_take && ((priv_q == PRIV_U) || mie_q) &&
                     !redirect_valid_q && !trap_valid;
  assign mret_fire = mret && !trap_valid && !irq_fire;
  assign csr_we    = wr_req && !illegal && !trap_valid && !irq_fire && !mret;

  assign vec_base    = {mtvec_q[31:2], 2'b00};
  assign trap_target = (irq_fire && mtvec_q[0]) ? vec_base + {25'b0, irq_code, 2'b00}
                                                : vec_base;

  always_ff @(posedge clk) begin
    if (reset) begin
      priv_q           <= PRIV_M;
      mie_q            <= 1'b0;
      mpie_q           <= 1'b0;
      mpp_q            <= PRIV_U;
      irq_en_q         <= '0;
      mtvec_q          <= {RESET_MTVEC[31:2], 1'b0,
                           VECTORED_EN && (RESET_MTVEC[1:0] == 2'b01)};
      mscratch_q       <= '0;
      mepc_q           <= '0;
      mcause_q         <= '0;
      mtval_q          <= '0;
      cy_inh_q         <= 1'b0;
      ir_inh_q         <= 1'b0;
      redirect_valid_q <= 1'b0;
      redirect_pc_q    <= '0;
    end else begin
      redirect_valid_q <= 1'b0;
      if (trap_valid || irq_fire) begin
        mepc_q           <= (trap_valid ? trap_pc : current_pc) & ~32'h3;
        mcause_q         <= trap_valid ? {27'b0, trap_cause} : {1'b1, 26'b0, irq_code};
        mtval_q          <= trap_valid ? trap_tval : 32'h0;
        mpie_q           <= mie_q;
        mie_q            <= 1'b0;
        mpp_q            <= priv_q;
        priv_q           <= PRIV_M;
        redirect_valid_q <= 1'b1;
        redirect_pc_q    <= trap_target;
      end else if (mret_fire) begin
        mie_q            <= mpie_q;
        mpie_q           <= 1'b1;
        priv_q           <= mpp_q;
        mpp_q            <= PRIV_U;
        redirect_valid_q <= 1'b1;
        redirect_pc_q    <= mepc_q;
      end else if (csr_we) begin
        case (csr_addr)
          CSR_MSTATUS: begin
            mie_q  <= wr_val[MSTATUS_MIE];
            mpie_q <= wr_val[MSTATUS_MPIE];
            mpp_q  <= (wr_val[MSTATUS_MPP_HI:MSTATUS_MPP_LO] == PRIV_M) ? PRIV_M : PRIV_U;
          end
          CSR_MIE:   irq_en_q <= wr_val & MIE_MASK;
          // Reserved MODE encodings collapse to direct.
          CSR_MTVEC: mtvec_q  <= {wr_val[31:2], 1'b0,
                                  VECTORED_EN && (wr_val[1:0] == 2'b01)};
          CSR_MCOUNTINHIBIT: begin
            cy_inh_q <= wr_val[0];
            ir_inh_q <= wr_val[2];
          end
          CSR_MSCRATCH: mscratch_q <= wr_val;
          CSR_MEPC:     mepc_q     <= wr_val & ~32'h3;
          CSR_MCAUSE:   mcause_q   <= wr_val;
          CSR_MTVAL:    mtval_q    <= wr_val;
          default: ;
        endcase
      end
    end
  end

  // A software write to either half replaces that cycle's increment.
  always_ff @(posedge clk) begin
    if (reset) begin
      mcycle_q   <= '0;
      minstret_q <= '0;
    end else begin
      if (csr_we && (csr_addr == CSR_MCYCLE))        mcycle_q[31:0]  <= wr_val;
      else if (csr_we && (csr_addr == CSR_MCYCLEH))  mcycle_q[63:32] <= wr_val;
      else if (!cy_inh_q)                            mcycle_q        <= mcycle_q + 64'd1;

      if (csr_we && (csr_addr == CSR_MINSTRET))       minstret_q[31:0]  <= wr_val;
      else if (csr_we && (csr_addr == CSR_MINSTRETH)) minstret_q[63:32] <= wr_val;
      else if (retire && !ir_inh_q)                   minstret_q        <= minstret_q + 64'd1;
    end
  end

  assign csr_rdata      = rd_val;
  assign csr_illegal    = illegal;
  assign redirect_valid = redirect_valid_q;
  assign redirect_pc    = redirect_pc_q;
  assign priv           = priv_q;

endmodule
